fetch_prefetch: RTL and testbench
=================================

Name: fetch_prefetch

Overview:
Parametrised successor to the single-instruction fetch stage. It fetches sequential 32-bit instructions from the MMU instruction port into a DEPTH-entry prefetch queue of {pc, instr} pairs. Entries are presented to decode through a valid/ready handshake. Redirects (branch/jump/trap) flush the queue, and any instruction-memory response still in flight is discarded safely. The block sits between the MMU imem port and the decode stage, replacing the free-running pc/newpc loop.

Parameters:
DEPTH, 4, number of prefetch queue entries (power of two, ≥2)
RESET_PC, 32'h0000_0000, fetch address after reset

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous, active-high reset
imem_addr  out  32  instruction fetch address, always word aligned
imem_read  out  1  fetch request
imem_drdy  in  1  MMU response valid; may assert in the same cycle as imem_read or any later cycle
imem_rdata  in  32  instruction word; valid only while imem_drdy=1
fetch_dec_valid  out  1  queue head is valid
fetch_dec_instr  out  32  queue head instruction
fetch_dec_pc  out  32  queue head pc
dec_fetch_ready  in  1  decode accepts head this cycle
redirect  in  1  flush and restart fetch
redirect_pc  in  32  new fetch pc; bits [1:0] forced to 0
fetch_count  out  $clog2(DEPTH)+1  current queue occupancy

Behaviour:
- Reset (rst=1 at posedge):
  - state=RUN, fetch_pc=RESET_PC, queue empty.
  - Outputs: imem_read=0 in the reset cycle, imem_addr=RESET_PC, fetch_dec_valid=0, fetch_count=0, fetch_dec_instr/pc=0.
  - rst overrides every other input, including a mid-transaction drdy.
- imem protocol:
  - At most one request outstanding.
  - While imem_read=1 and imem_drdy=0, imem_addr and imem_read hold stable.
  - A transaction completes in the cycle where imem_read=1 and imem_drdy=1.
- RUN state:
  - imem_read = (fetch_count < DEPTH); imem_addr = fetch_pc.
  - On completion: push {fetch_pc, imem_rdata}, then fetch_pc += 4 (32-bit wrap, 0xFFFF_FFFC → 0).
  - A one-cycle-latency memory (drdy same cycle) sustains 1 instruction/cycle.
- Queue:
  - Circular buffer with head/tail pointers; the head entry is registered.
  - fetch_dec_valid = (fetch_count != 0).
  - A pushed entry becomes visible the cycle after the push edge; there is no bypass.
  - Pop when valid && ready.
  - Push and pop in the same cycle leave the count unchanged.
  - Overflow is impossible: a request is issued only when count < DEPTH, and at most one is outstanding.
- Redirect (sampled at posedge):
  - Flushes the queue: count=0, and fetch_dec_valid=0 next cycle.
  - A pop in the same cycle is ignored.
  - A push in the same cycle is dropped. This covers a drdy arriving in the redirect cycle: that response is discarded, not queued.
  - If no request is outstanding, or the outstanding request completes in the redirect cycle: fetch_pc = redirect_pc & ~3, stay in RUN, and issue next cycle.
  - If a request is outstanding (read=1, drdy=0): latch the target and go to DISCARD.
- DISCARD state:
  - imem_read=1, imem_addr held at the old address until drdy.
  - The response is dropped (no push); then fetch_pc = latched target and state → RUN.
  - A further redirect in DISCARD overwrites the latched target and flushes the queue again.
  - fetch_dec_valid stays 0 throughout DISCARD.
- Decode ready is ignored while the queue is empty.

Test Plan:
- Reset then run, zero-latency memory returning word = addr ^ 0xA5A5_0000, ready=1 → decode receives pc 0,4,8,12… one per cycle from cycle 2 after reset release; each instr = pc ^ 0xA5A5_0000.
- ready=0 held, DEPTH=4 → fetch_count saturates at 4 and imem_read drops to 0. Raise ready: entries 0,4,8,12 are delivered in order, and fetching resumes at 16 with nothing lost or duplicated.
- 3-cycle-latency memory; redirect to 0x100 one cycle after a request to 0x20 issues → imem_addr holds 0x20 until drdy, and that word never reaches decode. The next request is 0x100, and the first decoded pc is 0x100.
- redirect to 0x203 asserted in the same cycle as drdy and dec pop → queue empty next cycle; the dropped word does not appear; the next fetch is 0x200.
- Two redirects during DISCARD (0x300, then 0x400) → only 0x400 is fetched after the stale response; no 0x300 fetch occurs.
- rst pulsed while a request is outstanding with 2 entries queued → next cycle valid=0, count=0, imem_read=0. Fetch restarts at RESET_PC, and the stale drdy is ignored.

Source files
------------

// File: rtl/fetch_prefetch.sv
// rtl/fetch_prefetch.sv - sequential instruction prefetcher with DEPTH-entry {pc, instr} queue
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   imem_addr/read/drdy/rdata    MMU instruction port, one request outstanding at most
//   fetch_dec_valid/instr/pc     queue head toward decode
//   dec_fetch_ready              decode accepts the head entry
//   redirect, redirect_pc        flush queue and restart fetch at redirect_pc (word aligned)
//   fetch_count                  current queue occupancy
module fetch_prefetch #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic [31:0]             imem_addr,
    output logic                    imem_read,
    input  logic                    imem_drdy,
    input  logic [31:0]             imem_rdata,
    output logic                    fetch_dec_valid,
    output logic [31:0]             fetch_dec_instr,
    output logic [31:0]             fetch_dec_pc,
    input  logic                    dec_fetch_ready,
    input  logic                    redirect,
    input  logic [31:0]             redirect_pc,
    output logic [$clog2(DEPTH):0]  fetch_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic {
        S_RUN     = 1'b0,
        S_DISCARD = 1'b1
    } state_t;

    state_t          r_state;
    logic [31:0]     r_fetch_pc;
    logic [31:0]     r_target;
    logic            r_rst_gap;
    logic [31:0]     r_q_pc    [DEPTH];
    logic [31:0]     r_q_instr [DEPTH];
    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_tail;
    logic [CW-1:0]   r_count;

    logic            w_complete;
    logic            w_push;
    logic            w_pop;
    logic [31:0]     w_redirect_pc;

    // The cycle right after reset never requests; after that, RUN requests
    // whenever there is room. Room cannot vanish while a request waits,
    // because the count only grows on completion, so read/addr stay stable.
    assign imem_read       = (r_state == S_DISCARD) | (~r_rst_gap & (r_count < FULL));
    assign imem_addr       = r_fetch_pc;
    assign fetch_dec_valid = (r_count != '0);
    assign fetch_dec_pc    = r_q_pc[r_head];
    assign fetch_dec_instr = r_q_instr[r_head];
    assign fetch_count     = r_count;

    assign w_redirect_pc = redirect_pc & ~32'h0000_0003;
    assign w_complete    = imem_read & imem_drdy;
    // A redirect wins over both queue operations: the arriving word is stale
    // and the head being popped is about to be flushed.
    assign w_push        = (r_state == S_RUN) & w_complete & ~redirect;
    assign w_pop         = fetch_dec_valid & dec_fetch_ready & ~redirect;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_RUN;
            r_fetch_pc <= RESET_PC;
            r_target   <= '0;
            r_rst_gap  <= 1'b1;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_q_pc[i]    <= '0;
                r_q_instr[i] <= '0;
            end
        end else begin
            r_rst_gap <= 1'b0;

            if (w_push) begin
                r_q_pc[r_tail]    <= r_fetch_pc;
                r_q_instr[r_tail] <= imem_rdata;
            end

            if (redirect) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) r_tail <= r_tail + PW'(1);
                if (w_pop)  r_head <= r_head + PW'(1);
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end

            case (r_state)
                S_RUN: begin
                    if (redirect) begin
                        if (imem_read && !imem_drdy) begin
                            // Request still in flight: keep addr/read stable
                            // and throw its response away later.
                            r_target <= w_redirect_pc;
                            r_state  <= S_DISCARD;
                        end else begin
                            r_fetch_pc <= w_redirect_pc;
                        end
                    end else if (w_complete) begin
                        r_fetch_pc <= r_fetch_pc + 32'd4;
                    end
                end
                S_DISCARD: begin
                    if (redirect) r_target <= w_redirect_pc;
                    if (imem_drdy) begin
                        r_fetch_pc <= redirect ? w_redirect_pc : r_target;
                        r_state    <= S_RUN;
                    end
                end
                default: r_state <= S_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_prefetch.sv
// tb/tb_fetch_prefetch.sv - scoreboard bench for fetch_prefetch
module tb_fetch_prefetch;

    localparam int          DEPTH = 4;
    localparam logic [31:0] KEY   = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_addr;
    logic        imem_read;
    logic        imem_drdy = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        fetch_dec_valid;
    logic [31:0] fetch_dec_instr;
    logic [31:0] fetch_dec_pc;
    logic        dec_fetch_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [$clog2(DEPTH):0] fetch_count;

    fetch_prefetch #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_addr       (imem_addr),
        .imem_read       (imem_read),
        .imem_drdy       (imem_drdy),
        .imem_rdata      (imem_rdata),
        .fetch_dec_valid (fetch_dec_valid),
        .fetch_dec_instr (fetch_dec_instr),
        .fetch_dec_pc    (fetch_dec_pc),
        .dec_fetch_ready (dec_fetch_ready),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .fetch_count     (fetch_count)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] exp_q[$];
    int          lat = 0;
    bit          stale = 1'b0;
    int          wait_cnt = 0;
    logic        p_read = 1'b0;
    logic        p_drdy = 1'b0;
    logic        p_rst = 1'b1;
    int          seen_300 = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, req);
        end
    endtask

    // Memory model: samples the previous cycle at negedge, drives the response
    // shortly after posedge. Word returned is addr ^ KEY after lat wait cycles.
    always @(negedge clk) begin
        p_read = imem_read;
        p_drdy = imem_drdy;
        p_rst  = rst;
        if (imem_read && imem_addr == 32'h0000_0300) seen_300++;
    end

    always begin
        @(posedge clk);
        #2;
        if (p_rst)                wait_cnt = 0;
        else if (p_read && p_drdy) wait_cnt = 0;
        else if (p_read)          wait_cnt++;
        if (stale) begin
            imem_drdy  = 1'b1;
            imem_rdata = 32'hDEAD_BEEF;
        end else if (imem_read && wait_cnt >= lat) begin
            imem_drdy  = 1'b1;
            imem_rdata = imem_addr ^ KEY;
        end else begin
            imem_drdy  = 1'b0;
            imem_rdata = '0;
        end
    end

    // Decode-side monitor: a transfer happens on valid && ready without redirect.
    always @(negedge clk) begin
        if (!rst && fetch_dec_valid && dec_fetch_ready && !redirect) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pc", fetch_dec_pc, 32'hFFFF_FFFF);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check("dec_pc", fetch_dec_pc, e);
                check("dec_instr", fetch_dec_instr, e ^ KEY);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect = 1'b0;
        dec_fetch_ready = 1'b0;
        stale = 1'b0;
        exp_q.delete();
        step();
        step();
        step();
        check("rst_valid", 32'(fetch_dec_valid), 32'd0);
        check("rst_count", 32'(fetch_count), 32'd0);
        check("rst_read", 32'(imem_read), 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_pc", fetch_dec_pc, 32'h0);
        check("rst_instr", fetch_dec_instr, 32'h0);
        rst = 1'b0;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) step();
        dec_fetch_ready = 1'b0;
        check("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit found;

        // streaming at one instruction per cycle
        lat = 0;
        do_reset();
        dec_fetch_ready = 1'b1;
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
        step();
        check("t1_read", 32'(imem_read), 32'd1);
        check("t1_addr", imem_addr, 32'h0);
        check("t1_valid0", 32'(fetch_dec_valid), 32'd0);
        step();
        check("t1_valid1", 32'(fetch_dec_valid), 32'd1);
        check("t1_head", fetch_dec_pc, 32'h0);
        for (int i = 0; i < 8; i++) step();
        dec_fetch_ready = 1'b0;
        check("t1_left", 32'(exp_q.size()), 32'd0);

        // back-pressure fills the queue, then drains in order
        do_reset();
        for (int i = 0; i < 10; i++) step();
        check("t2_count", 32'(fetch_count), 32'd4);
        check("t2_read", 32'(imem_read), 32'd0);
        check("t2_addr", imem_addr, 32'h10);
        check("t2_head", fetch_dec_pc, 32'h0);
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
        dec_fetch_ready = 1'b1;
        for (int i = 0; i < 8; i++) step();
        dec_fetch_ready = 1'b0;
        check("t2_left", 32'(exp_q.size()), 32'd0);

        // redirect while a slow request is outstanding
        lat = 3;
        do_reset();
        dec_fetch_ready = 1'b1;
        for (int i = 0; i < 7; i++) exp_q.push_back(32'(i * 4));
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (imem_read && imem_addr == 32'h20) begin
                found = 1'b1;
                break;
            end
        end
        check("t3_reach20", 32'(found), 32'd1);
        redirect = 1'b1;
        redirect_pc = 32'h100;
        step();
        redirect = 1'b0;
        step();
        check("t3_hold_addr", imem_addr, 32'h20);
        check("t3_hold_read", 32'(imem_read), 32'd1);
        check("t3_valid", 32'(fetch_dec_valid), 32'd0);
        step();
        check("t3_hold_addr2", imem_addr, 32'h20);
        step();
        check("t3_new_addr", imem_addr, 32'h100);
        check("t3_new_read", 32'(imem_read), 32'd1);
        check("t3_count", 32'(fetch_count), 32'd0);
        drain(60);

        // redirect together with drdy and a pop
        lat = 0;
        do_reset();
        dec_fetch_ready = 1'b1;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        exp_q.push_back(32'h200);
        exp_q.push_back(32'h204);
        exp_q.push_back(32'h208);
        for (int i = 0; i < 5; i++) step();
        redirect = 1'b1;
        redirect_pc = 32'h203;
        step();
        redirect = 1'b0;
        check("t4_valid", 32'(fetch_dec_valid), 32'd0);
        check("t4_count", 32'(fetch_count), 32'd0);
        check("t4_addr", imem_addr, 32'h200);
        check("t4_read", 32'(imem_read), 32'd1);
        for (int i = 0; i < 4; i++) step();
        dec_fetch_ready = 1'b0;
        check("t4_left", 32'(exp_q.size()), 32'd0);

        // two redirects during DISCARD: last target wins
        lat = 3;
        do_reset();
        seen_300 = 0;
        dec_fetch_ready = 1'b1;
        exp_q.push_back(32'h400);
        exp_q.push_back(32'h404);
        step();
        redirect = 1'b1;
        redirect_pc = 32'h300;
        step();
        redirect_pc = 32'h400;
        step();
        redirect = 1'b0;
        check("t5_hold_addr", imem_addr, 32'h0);
        check("t5_hold_read", 32'(imem_read), 32'd1);
        check("t5_valid", 32'(fetch_dec_valid), 32'd0);
        step();
        step();
        check("t5_new_addr", imem_addr, 32'h400);
        drain(60);
        check("t5_no_300", 32'(seen_300), 32'd0);

        // reset with a request outstanding and two entries queued
        lat = 3;
        do_reset();
        for (int i = 0; i < 10; i++) step();
        check("t6_count_pre", 32'(fetch_count), 32'd2);
        check("t6_addr_pre", imem_addr, 32'h8);
        rst = 1'b1;
        step();
        rst = 1'b0;
        stale = 1'b1;
        check("t6_valid", 32'(fetch_dec_valid), 32'd0);
        check("t6_count", 32'(fetch_count), 32'd0);
        check("t6_read", 32'(imem_read), 32'd0);
        check("t6_addr", imem_addr, 32'h0);
        step();
        stale = 1'b0;
        check("t6_count_after", 32'(fetch_count), 32'd0);
        check("t6_read_after", 32'(imem_read), 32'd1);
        check("t6_addr_after", imem_addr, 32'h0);
        dec_fetch_ready = 1'b1;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        drain(60);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
